// File: rtl/fifo_wr_agent.sv
// Write-side FIFO traffic agent: emits NUM_BURSTS bursts of BURST_LEN sequential
// words starting at SEED, honouring wfull back-pressure and reporting stall statistics.
module fifo_wr_agent #(
  parameter int          DATA_WIDTH = 8,
  parameter int          BURST_LEN  = 4,
  parameter int          GAP_CYCLES = 3,
  parameter int          NUM_BURSTS = 2,
  parameter int unsigned SEED       = 8'h10
) (
  input  logic                  sys_wclk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic                  wfull,
  output logic                  wen,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           words_sent,
  output logic [15:0]           stall_cycles
);

  typedef enum logic [1:0] {IDLE, BURST, GAP, DONE} state_t;

  localparam logic [DATA_WIDTH-1:0] SEED_W     = DATA_WIDTH'(SEED);
  localparam logic [15:0]           LAST_WORD  = 16'(BURST_LEN - 1);
  localparam logic [15:0]           LAST_BURST = 16'(NUM_BURSTS - 1);
  localparam logic [31:0]           LAST_GAP   = 32'(GAP_CYCLES - 1);

  state_t      state_reg;
  logic [15:0] word_cnt_reg;
  logic [15:0] burst_cnt_reg;
  logic [31:0] gap_cnt_reg;

  always_ff @(posedge sys_wclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg     <= IDLE;
      word_cnt_reg  <= '0;
      burst_cnt_reg <= '0;
      gap_cnt_reg   <= '0;
      wen           <= 1'b0;
      wdata         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      words_sent    <= '0;
      stall_cycles  <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg     <= BURST;
            word_cnt_reg  <= '0;
            burst_cnt_reg <= '0;
            gap_cnt_reg   <= '0;
            wen           <= 1'b1;
            wdata         <= SEED_W;
            busy          <= 1'b1;
            done          <= 1'b0;
            words_sent    <= '0;
            stall_cycles  <= '0;
          end
        end
        BURST: begin
          if (wen && !wfull) begin
            words_sent <= words_sent + 16'd1;
            wdata      <= wdata + DATA_WIDTH'(1);
            if (word_cnt_reg == LAST_WORD) begin
              word_cnt_reg <= '0;
              wen          <= 1'b0;
              if (burst_cnt_reg == LAST_BURST) begin
                state_reg <= DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
              end else begin
                burst_cnt_reg <= burst_cnt_reg + 16'd1;
                gap_cnt_reg   <= '0;
                state_reg     <= GAP;
              end
            end else begin
              word_cnt_reg <= word_cnt_reg + 16'd1;
            end
          end else if (wen && wfull) begin
            // Stall: hold the word on the bus; the counter sticks at its maximum.
            if (stall_cycles != 16'hFFFF)
              stall_cycles <= stall_cycles + 16'd1;
          end
        end
        GAP: begin
          if (gap_cnt_reg == LAST_GAP) begin
            gap_cnt_reg <= '0;
            wen         <= 1'b1;
            state_reg   <= BURST;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 32'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_agent.sv
// Directed bench for fifo_wr_agent: vector table for full runs plus hand sequences
// for wrap-around, asynchronous reset and stall-counter saturation.
module tb_fifo_wr_agent;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, wfull;
  logic        wen, busy, done;
  logic [7:0]  wdata;
  logic [15:0] words_sent, stall_cycles;

  logic        d2_start, d2_wfull;
  logic        d2_wen, d2_busy, d2_done;
  logic [7:0]  d2_wdata;
  logic [15:0] d2_words_sent, d2_stall_cycles;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_wr_agent dut (
    .sys_wclk(clk), .sys_rst(rst), .start(start), .wfull(wfull),
    .wen(wen), .wdata(wdata), .busy(busy), .done(done),
    .words_sent(words_sent), .stall_cycles(stall_cycles)
  );

  fifo_wr_agent #(.DATA_WIDTH(8), .BURST_LEN(4), .GAP_CYCLES(3), .NUM_BURSTS(1), .SEED(8'hFE)) dut2 (
    .sys_wclk(clk), .sys_rst(rst), .start(d2_start), .wfull(d2_wfull),
    .wen(d2_wen), .wdata(d2_wdata), .busy(d2_busy), .done(d2_done),
    .words_sent(d2_words_sent), .stall_cycles(d2_stall_cycles)
  );

  typedef struct {
    logic        start;
    logic        wfull;
    logic        wen;
    logic [7:0]  wdata;
    logic        busy;
    logic        done;
    logic [15:0] ws;
    logic [15:0] st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic f, input logic e, input logic [7:0] d,
                     input logic b, input logic dn, input logic [15:0] ws, input logic [15:0] st);
    vec_t v;
    v.start = s; v.wfull = f; v.wen = e; v.wdata = d;
    v.busy = b; v.done = dn; v.ws = ws; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_main(input string tag, input logic e, input logic [7:0] d, input logic b,
                            input logic dn, input logic [15:0] ws, input logic [15:0] st);
    check({tag, ".wen"}, 32'(wen), 32'(e));
    if (e) check({tag, ".wdata"}, 32'(wdata), 32'(d));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(dn));
    check({tag, ".words_sent"}, 32'(words_sent), 32'(ws));
    check({tag, ".stall"}, 32'(stall_cycles), 32'(st));
  endtask

  initial begin
    logic [7:0] d2_exp [5];
    d2_exp[0] = 8'hFE; d2_exp[1] = 8'hFF; d2_exp[2] = 8'h00; d2_exp[3] = 8'h01; d2_exp[4] = 8'h02;

    // Run 1: defaults, no back-pressure
    add(1,0, 1,8'h10,1,0,0,0);
    add(0,0, 1,8'h11,1,0,1,0);
    add(0,0, 1,8'h12,1,0,2,0);
    add(0,0, 1,8'h13,1,0,3,0);
    add(0,0, 0,8'h14,1,0,4,0);
    add(0,0, 0,8'h14,1,0,4,0);
    add(0,0, 0,8'h14,1,0,4,0);
    add(0,0, 1,8'h14,1,0,4,0);
    add(0,0, 1,8'h15,1,0,5,0);
    add(0,0, 1,8'h16,1,0,6,0);
    add(0,0, 1,8'h17,1,0,7,0);
    add(0,0, 0,8'h18,0,1,8,0);
    add(0,0, 0,8'h18,0,1,8,0);
    // Run 2 from DONE: two stalls on word 12, wfull and start toggled in GAP
    add(1,0, 1,8'h10,1,0,0,0);
    add(0,0, 1,8'h11,1,0,1,0);
    add(0,0, 1,8'h12,1,0,2,0);
    add(0,1, 1,8'h12,1,0,2,1);
    add(0,1, 1,8'h12,1,0,2,2);
    add(0,0, 1,8'h13,1,0,3,2);
    add(0,0, 0,8'h14,1,0,4,2);
    add(1,1, 0,8'h14,1,0,4,2);
    add(0,1, 0,8'h14,1,0,4,2);
    add(0,1, 1,8'h14,1,0,4,2);
    add(0,0, 1,8'h15,1,0,5,2);
    add(0,0, 1,8'h16,1,0,6,2);
    add(0,0, 1,8'h17,1,0,7,2);
    add(0,0, 0,8'h18,0,1,8,2);
    add(0,1, 0,8'h18,0,1,8,2);
    // Run 3 from DONE: counters clear, fresh data
    add(1,0, 1,8'h10,1,0,0,0);
    add(0,0, 1,8'h11,1,0,1,0);
    add(0,0, 1,8'h12,1,0,2,0);

    rst = 1'b1; start = 0; wfull = 0; d2_start = 0; d2_wfull = 0;
    #1;
    check_main("reset", 0, 8'h00, 0, 0, 0, 0);
    check("reset.wdata", 32'(wdata), 32'h0);
    check("reset.d2_wen", 32'(d2_wen), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    check_main("idle", 0, 8'h00, 0, 0, 0, 0);

    // Wrap-around instance: SEED=FE, single burst
    d2_start = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      d2_start = 0;
      check($sformatf("wrap[%0d].wen", i), 32'(d2_wen), (i < 4) ? 32'd1 : 32'd0);
      check($sformatf("wrap[%0d].wdata", i), 32'(d2_wdata), 32'(d2_exp[i]));
      check($sformatf("wrap[%0d].words_sent", i), 32'(d2_words_sent), 32'(i));
    end
    check("wrap.done", 32'(d2_done), 32'd1);
    check("wrap.busy", 32'(d2_busy), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start;
      wfull = vecs[i].wfull;
      @(posedge clk); #1;
      $display("vec %0d: start=%0b wfull=%0b -> wen=%0b wdata=%02h busy=%0b done=%0b ws=%0d st=%0d",
               i, start, wfull, wen, wdata, busy, done, words_sent, stall_cycles);
      check_main($sformatf("vec[%0d]", i), vecs[i].wen, vecs[i].wdata, vecs[i].busy,
                 vecs[i].done, vecs[i].ws, vecs[i].st);
    end
    start = 0; wfull = 0;

    // Asynchronous reset mid-burst, between edges
    #2 rst = 1'b1;
    #1;
    check_main("async_rst", 0, 8'h00, 0, 0, 0, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst[%0d].wen", i), 32'(wen), 32'd0);
      check($sformatf("post_rst[%0d].words_sent", i), 32'(words_sent), 32'd0);
    end

    // Saturating stall counter
    start = 1;
    @(posedge clk); #1;
    start = 0;
    wfull = 1;
    check_main("sat_start", 1, 8'h10, 1, 0, 0, 0);
    for (int i = 1; i <= 70000; i++) begin
      @(posedge clk); #1;
      if (i == 65534) check("sat.pre", 32'(stall_cycles), 32'hFFFE);
    end
    $display("saturation: stall=%0h wdata=%02h wen=%0b", stall_cycles, wdata, wen);
    check_main("sat_end", 1, 8'h10, 1, 0, 0, 16'hFFFF);
    wfull = 0;
    @(posedge clk); #1;
    check_main("sat_release", 1, 8'h11, 1, 0, 1, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
